cu_microseq: RTL and testbench

//  Parametrised microprogrammed sequencer; next generation of the PDUA control unit.

---
 rtl/cu_microseq_if.sv | 33 +++
 rtl/cu_microseq.sv | 154 +++++++++++++++
 tb/tb_cu_microseq.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cu_microseq_if.sv
// Bundles the sequencer's connections to the IR/flags, the microcode ROM and the datapath.
interface cu_microseq_if #(
  parameter int OPCODE_W = 5,
  parameter int UADDR_W  = 8,
  parameter int CTRL_W   = 24
);
  localparam int UWORD_W = CTRL_W + 6 + UADDR_W;

  logic [OPCODE_W-1:0] opcode;
  logic                C;
  logic                N;
  logic                P;
  logic                Z;
  logic                int_req;
  logic                mem_ready;
  logic [UADDR_W-1:0]  uaddr;
  logic [UWORD_W-1:0]  uword;
  logic [CTRL_W-1:0]   ctrl;
  logic                int_ack;
  logic                bus_err;

  // Sequencer side.
  modport master (
    input  opcode, C, N, P, Z, int_req, mem_ready, uword,
    output uaddr, ctrl, int_ack, bus_err
  );

  // Surrounding system side: ROM, IR/flags, memory and interrupt sources.
  modport slave (
    output opcode, C, N, P, Z, int_req, mem_ready, uword,
    input  uaddr, ctrl, int_ack, bus_err
  );
endinterface

// File: rtl/cu_microseq.sv
// Microprogrammed control sequencer. The uPC addresses an external combinational
// microcode ROM; each microword carries a control word plus a sequencing op,
// a branch condition and a target address.
module cu_microseq #(
  parameter int                 OPCODE_W   = 5,
  parameter int                 UADDR_W    = 8,
  parameter int                 CTRL_W     = 24,
  parameter logic [UADDR_W-1:0] FETCH_ADDR = 8'h00,
  parameter logic [UADDR_W-1:0] INT_VEC    = 8'hF0,
  parameter logic [UADDR_W-1:0] ERR_VEC    = 8'hF8,
  parameter int                 WAIT_MAX   = 15
) (
  input  logic          clk,
  input  logic          rst,
  cu_microseq_if.master bus
);
  localparam int WCNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  localparam logic [2:0] SEQ_NEXT     = 3'b000;
  localparam logic [2:0] SEQ_JUMP     = 3'b001;
  localparam logic [2:0] SEQ_BRANCH   = 3'b010;
  localparam logic [2:0] SEQ_DISPATCH = 3'b011;
  localparam logic [2:0] SEQ_FETCH    = 3'b100;
  localparam logic [2:0] SEQ_WAIT     = 3'b101;
  localparam logic [2:0] SEQ_EI       = 3'b110;
  localparam logic [2:0] SEQ_DI       = 3'b111;

  typedef enum logic [1:0] {
    S_RST = 2'd0,
    S_RUN = 2'd1,
    S_INT = 2'd2
  } state_t;

  state_t              state_r;
  logic [UADDR_W-1:0]  upc_r;
  logic                ien_r;
  logic [WCNT_W-1:0]   wait_cnt_r;
  logic                int_ack_r;
  logic                bus_err_r;

  logic [CTRL_W-1:0]   uw_ctrl_s;
  logic [2:0]          uw_seq_s;
  logic [2:0]          uw_cond_s;
  logic [UADDR_W-1:0]  uw_target_s;
  logic [UADDR_W-1:0]  upc_inc_s;
  logic [UADDR_W-1:0]  upc_disp_s;
  logic                cond_ok_s;

  // Condition selector over the live ALU flags.
  function automatic logic cond_eval(input logic [2:0] sel, input logic c, input logic n,
                                     input logic p, input logic z);
    logic res;
    case (sel)
      3'b000:  res = 1'b1;
      3'b001:  res = c;
      3'b010:  res = n;
      3'b011:  res = p;
      3'b100:  res = z;
      3'b101:  res = ~c;
      3'b110:  res = ~n;
      3'b111:  res = ~z;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  assign {uw_ctrl_s, uw_seq_s, uw_cond_s, uw_target_s} = bus.uword;

  // Address arithmetic wraps naturally modulo 2**UADDR_W.
  assign upc_inc_s  = upc_r + UADDR_W'(1);
  assign upc_disp_s = uw_target_s + UADDR_W'(bus.opcode);
  assign cond_ok_s  = cond_eval(uw_cond_s, bus.C, bus.N, bus.P, bus.Z);

  assign bus.uaddr   = upc_r;
  assign bus.int_ack = int_ack_r;
  assign bus.bus_err = bus_err_r;

  // Control word follows the ROM in the same cycle, but is forced idle outside normal execution.
  always_comb begin
    bus.ctrl = {CTRL_W{1'b0}};
    if (state_r == S_RUN) begin
      bus.ctrl = uw_ctrl_s;
    end else begin
      bus.ctrl = {CTRL_W{1'b0}};
    end
  end

  // Sequencer FSM: uPC update, interrupt entry, memory wait timeout and sticky bus error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= S_RST;
      upc_r      <= FETCH_ADDR;
      ien_r      <= 1'b0;
      wait_cnt_r <= {WCNT_W{1'b0}};
      int_ack_r  <= 1'b0;
      bus_err_r  <= 1'b0;
    end else begin
      int_ack_r <= 1'b0;
      case (state_r)
        S_RST: begin
          state_r <= S_RUN;
        end
        S_INT: begin
          ien_r   <= 1'b0;
          upc_r   <= INT_VEC;
          state_r <= S_RUN;
        end
        S_RUN: begin
          case (uw_seq_s)
            SEQ_NEXT:     upc_r <= upc_inc_s;
            SEQ_JUMP:     upc_r <= uw_target_s;
            SEQ_BRANCH:   upc_r <= cond_ok_s ? uw_target_s : upc_inc_s;
            SEQ_DISPATCH: upc_r <= upc_disp_s;
            SEQ_FETCH: begin
              // Interrupts are only taken at an instruction boundary.
              if (bus.int_req && ien_r) begin
                state_r   <= S_INT;
                int_ack_r <= 1'b1;
              end else begin
                upc_r <= FETCH_ADDR;
              end
            end
            SEQ_WAIT: begin
              // A late completion still wins over the timeout in the same cycle.
              if (bus.mem_ready) begin
                upc_r      <= upc_inc_s;
                wait_cnt_r <= {WCNT_W{1'b0}};
              end else if (wait_cnt_r == WCNT_W'(WAIT_MAX - 1)) begin
                bus_err_r  <= 1'b1;
                upc_r      <= ERR_VEC;
                wait_cnt_r <= {WCNT_W{1'b0}};
              end else begin
                wait_cnt_r <= wait_cnt_r + WCNT_W'(1);
              end
            end
            SEQ_EI: begin
              ien_r <= 1'b1;
              upc_r <= upc_inc_s;
            end
            SEQ_DI: begin
              ien_r <= 1'b0;
              upc_r <= upc_inc_s;
            end
            default: upc_r <= FETCH_ADDR;
          endcase
        end
        default: begin
          state_r <= S_RST;
          upc_r   <= FETCH_ADDR;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cu_microseq.sv
// Directed bench for cu_microseq: a vector table for single-step sequencing ops and
// hand-written sequences for reset, wait/timeout and interrupt entry.
module tb_cu_microseq;
  localparam logic [2:0] NEXT = 3'b000, JUMP = 3'b001, BRANCH = 3'b010, DISPATCH = 3'b011;
  localparam logic [2:0] FETCH = 3'b100, WAIT = 3'b101, EI = 3'b110, DI = 3'b111;

  logic clk;
  logic rst;
  logic [37:0] rom [256];
  int n_tests;
  int n_fail;

  cu_microseq_if #(.OPCODE_W(5), .UADDR_W(8), .CTRL_W(24)) bus ();

  cu_microseq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  assign bus.uword = rom[bus.uaddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] at;
    logic [2:0] seq;
    logic [2:0] cond;
    logic [7:0] target;
    logic [4:0] opcode;
    logic [3:0] cnpz;
    logic       int_req;
    logic       mem_ready;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[20];

  function automatic logic [23:0] ctrl_of(input logic [7:0] a);
    return {8'hC3, 8'h5A, a};
  endfunction

  function automatic logic [37:0] mkw(input logic [7:0] a, input logic [2:0] s,
                                      input logic [2:0] c, input logic [7:0] t);
    return {ctrl_of(a), s, c, t};
  endfunction

  function automatic vec_t mk(input logic [7:0] at, input logic [2:0] s, input logic [2:0] c,
                              input logic [7:0] t, input logic [4:0] op, input logic [3:0] f,
                              input logic ir, input logic mr, input logic [7:0] e);
    vec_t v;
    v.at = at; v.seq = s; v.cond = c; v.target = t; v.opcode = op;
    v.cnpz = f; v.int_req = ir; v.mem_ready = mr; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 256; i++) rom[i] = mkw(8'(i), NEXT, 3'b000, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic set_inputs(input logic [4:0] op, input logic [3:0] f, input logic ir,
                            input logic mr);
    bus.opcode = op;
    {bus.C, bus.N, bus.P, bus.Z} = f;
    bus.int_req = ir;
    bus.mem_ready = mr;
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst = 1'b0;
    set_inputs(5'h00, 4'b0000, 1'b0, 1'b0);
    rom_clear();

    //              at     seq       cond    target opcode flags CNPZ  irq  rdy  exp
    vecs[0]  = mk(8'h10, NEXT,     3'b000, 8'h00, 5'h00, 4'b0000, 1'b0, 1'b0, 8'h11);
    vecs[1]  = mk(8'hFF, NEXT,     3'b000, 8'h00, 5'h00, 4'b0000, 1'b0, 1'b0, 8'h00);
    vecs[2]  = mk(8'h10, JUMP,     3'b000, 8'h55, 5'h00, 4'b0000, 1'b0, 1'b0, 8'h55);
    vecs[3]  = mk(8'h10, DISPATCH, 3'b000, 8'h20, 5'h0D, 4'b0000, 1'b0, 1'b0, 8'h2D);
    vecs[4]  = mk(8'h10, DISPATCH, 3'b000, 8'hF0, 5'h1F, 4'b0000, 1'b0, 1'b0, 8'h0F);
    vecs[5]  = mk(8'h10, BRANCH,   3'b100, 8'h40, 5'h00, 4'b0001, 1'b0, 1'b0, 8'h40);
    vecs[6]  = mk(8'h10, BRANCH,   3'b100, 8'h40, 5'h00, 4'b0000, 1'b0, 1'b0, 8'h11);
    vecs[7]  = mk(8'h10, BRANCH,   3'b101, 8'h40, 5'h00, 4'b0000, 1'b0, 1'b0, 8'h40);
    vecs[8]  = mk(8'h10, BRANCH,   3'b101, 8'h40, 5'h00, 4'b1000, 1'b0, 1'b0, 8'h11);
    vecs[9]  = mk(8'h10, BRANCH,   3'b000, 8'h40, 5'h00, 4'b0000, 1'b0, 1'b0, 8'h40);
    vecs[10] = mk(8'h10, BRANCH,   3'b001, 8'h40, 5'h00, 4'b1000, 1'b0, 1'b0, 8'h40);
    vecs[11] = mk(8'h10, BRANCH,   3'b010, 8'h40, 5'h00, 4'b0100, 1'b0, 1'b0, 8'h40);
    vecs[12] = mk(8'h10, BRANCH,   3'b010, 8'h40, 5'h00, 4'b0000, 1'b0, 1'b0, 8'h11);
    vecs[13] = mk(8'h10, BRANCH,   3'b011, 8'h40, 5'h00, 4'b0010, 1'b0, 1'b0, 8'h40);
    vecs[14] = mk(8'h10, BRANCH,   3'b110, 8'h40, 5'h00, 4'b0000, 1'b0, 1'b0, 8'h40);
    vecs[15] = mk(8'h10, BRANCH,   3'b111, 8'h40, 5'h00, 4'b0001, 1'b0, 1'b0, 8'h11);
    vecs[16] = mk(8'h10, FETCH,    3'b000, 8'h77, 5'h00, 4'b0000, 1'b1, 1'b0, 8'h00);
    vecs[17] = mk(8'h10, EI,       3'b000, 8'h00, 5'h00, 4'b0000, 1'b0, 1'b0, 8'h11);
    vecs[18] = mk(8'h10, DI,       3'b000, 8'h00, 5'h00, 4'b0000, 1'b0, 1'b0, 8'h11);
    vecs[19] = mk(8'h10, WAIT,     3'b000, 8'h00, 5'h00, 4'b0000, 1'b0, 1'b1, 8'h11);

    // Reset state while rst is held low.
    #1;
    check("rst_uaddr", 32'(bus.uaddr), 32'h00);
    check("rst_ctrl", 32'(bus.ctrl), 32'h0);
    check("rst_int_ack", 32'(bus.int_ack), 32'h0);
    check("rst_bus_err", 32'(bus.bus_err), 32'h0);

    // Table: JUMP from 00 to the op under test, then check the op's successor.
    for (int i = 0; i < 20; i++) begin
      rom_clear();
      rom[8'h00] = mkw(8'h00, JUMP, 3'b000, vecs[i].at);
      rom[vecs[i].at] = mkw(vecs[i].at, vecs[i].seq, vecs[i].cond, vecs[i].target);
      set_inputs(vecs[i].opcode, vecs[i].cnpz, vecs[i].int_req, vecs[i].mem_ready);
      do_reset();
      step();
      step();
      check($sformatf("v%0d_at", i), 32'(bus.uaddr), 32'(vecs[i].at));
      check($sformatf("v%0d_ctrl", i), 32'(bus.ctrl), 32'(ctrl_of(vecs[i].at)));
      step();
      check($sformatf("v%0d_next", i), 32'(bus.uaddr), 32'(vecs[i].exp));
    end

    // WAIT at 30: ready on the 3rd stall cycle.
    rom_clear();
    rom[8'h00] = mkw(8'h00, JUMP, 3'b000, 8'h30);
    rom[8'h30] = mkw(8'h30, WAIT, 3'b000, 8'h00);
    set_inputs(5'h00, 4'b0000, 1'b0, 1'b0);
    do_reset();
    step();
    step();
    check("w3_c1", 32'(bus.uaddr), 32'h30);
    step();
    check("w3_c2", 32'(bus.uaddr), 32'h30);
    step();
    check("w3_c3", 32'(bus.uaddr), 32'h30);
    bus.mem_ready = 1'b1;
    step();
    check("w3_done", 32'(bus.uaddr), 32'h31);
    check("w3_bus_err", 32'(bus.bus_err), 32'h0);

    // WAIT: ready arrives on the last allowed cycle, beating the timeout.
    bus.mem_ready = 1'b0;
    do_reset();
    step();
    step();
    for (int k = 0; k < 14; k++) step();
    check("wlast_still", 32'(bus.uaddr), 32'h30);
    bus.mem_ready = 1'b1;
    step();
    check("wlast_adv", 32'(bus.uaddr), 32'h31);
    check("wlast_no_err", 32'(bus.bus_err), 32'h0);

    // WAIT: never ready -> timeout after 15 cycles to ERR_VEC, sticky bus_err.
    bus.mem_ready = 1'b0;
    do_reset();
    step();
    step();
    for (int k = 0; k < 14; k++) begin
      check($sformatf("wto_stall%0d", k), 32'(bus.uaddr), 32'h30);
      step();
    end
    check("wto_stall14", 32'(bus.uaddr), 32'h30);
    check("wto_no_err_yet", 32'(bus.bus_err), 32'h0);
    step();
    check("wto_errvec", 32'(bus.uaddr), 32'hF8);
    check("wto_bus_err", 32'(bus.bus_err), 32'h1);
    check("wto_err_ctrl", 32'(bus.ctrl), 32'(ctrl_of(8'hF8)));
    step();
    step();
    check("wto_err_run", 32'(bus.uaddr), 32'hFA);
    check("wto_sticky", 32'(bus.bus_err), 32'h1);

    // Reset asserted mid-WAIT: immediate clear, one idle cycle, then fetch routine.
    do_reset();
    step();
    step();
    step();
    check("rmw_in_wait", 32'(bus.uaddr), 32'h30);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rmw_async_uaddr", 32'(bus.uaddr), 32'h00);
    check("rmw_async_ctrl", 32'(bus.ctrl), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rmw_idle_uaddr", 32'(bus.uaddr), 32'h00);
    check("rmw_idle_ctrl", 32'(bus.ctrl), 32'h0);
    step();
    check("rmw_run_uaddr", 32'(bus.uaddr), 32'h00);
    check("rmw_run_ctrl", 32'(bus.ctrl), 32'(ctrl_of(8'h00)));

    // EI then FETCH with int_req: one S_INT cycle, then INT_VEC with interrupts disabled.
    rom_clear();
    rom[8'h00] = mkw(8'h00, JUMP, 3'b000, 8'h10);
    rom[8'h10] = mkw(8'h10, EI, 3'b000, 8'h00);
    rom[8'h11] = mkw(8'h11, FETCH, 3'b000, 8'h00);
    rom[8'hF0] = mkw(8'hF0, FETCH, 3'b000, 8'h00);
    set_inputs(5'h00, 4'b0000, 1'b1, 1'b0);
    do_reset();
    step();
    step();
    step();
    check("int_at_fetch", 32'(bus.uaddr), 32'h11);
    check("int_no_ack_yet", 32'(bus.int_ack), 32'h0);
    step();
    check("int_ack", 32'(bus.int_ack), 32'h1);
    check("int_ctrl_idle", 32'(bus.ctrl), 32'h0);
    step();
    check("int_vec", 32'(bus.uaddr), 32'hF0);
    check("int_ack_drop", 32'(bus.int_ack), 32'h0);
    check("int_vec_ctrl", 32'(bus.ctrl), 32'(ctrl_of(8'hF0)));
    step();
    check("int_ien_cleared", 32'(bus.uaddr), 32'h00);
    check("int_ien_no_ack", 32'(bus.int_ack), 32'h0);

    // EI, DI, FETCH with int_req held: interrupt ignored, fetch taken.
    rom[8'h11] = mkw(8'h11, DI, 3'b000, 8'h00);
    rom[8'h12] = mkw(8'h12, FETCH, 3'b000, 8'h00);
    do_reset();
    for (int k = 0; k < 4; k++) step();
    check("di_at_fetch", 32'(bus.uaddr), 32'h12);
    step();
    check("di_fetch", 32'(bus.uaddr), 32'h00);
    check("di_no_ack", 32'(bus.int_ack), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
